// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter (open-drain lines driven via output enables).
// Optional single automatic retry on failure when PS2_TX_RETRY_EN is defined.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_START = IW'(INHIBIT_CYCLES - 2);
    localparam logic [IW-1:0] INH_ONE   = IW'(1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WD_ONE    = WW'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;
    localparam logic [2:0] S_FAIL    = 3'd6;

    logic [2:0]    r_state;
    logic          r_clk_meta;
    logic          r_clk_sync;
    logic          r_clk_prev;
    logic          r_dat_meta;
    logic          r_dat_sync;
    logic [7:0]    r_data;
    logic [9:0]    r_shift;
    logic [3:0]    r_bitcnt;
    logic [IW-1:0] r_inh;
    logic [WW-1:0] r_wd;
    logic          r_clk_oe;
    logic          r_dat_oe;
    logic          r_busy;
    logic          r_done;
    logic          r_error;

    logic w_fall;
    logic w_wd_active;
    logic w_timeout;
    logic w_nack;
    logic w_retry;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_i;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_dat_i;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_fall      = r_clk_prev & ~r_clk_sync;
    assign w_wd_active = (r_state == S_START) || (r_state == S_SHIFT) ||
                         (r_state == S_ACK)   || (r_state == S_RELEASE);
    assign w_timeout   = w_wd_active & ~w_fall & (r_wd == WD_LAST);
    assign w_nack      = (r_state == S_ACK) & w_fall & r_dat_sync;

`ifdef PS2_TX_RETRY_EN
    logic r_retried;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retried <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_retried <= 1'b0;
        end else if (r_state == S_FAIL) begin
            r_retried <= 1'b1;
        end
    end

    assign w_retry = ~r_retried;
`else
    assign w_retry = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_data   <= '0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_inh    <= '0;
            r_wd     <= '0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (w_wd_active) begin
                r_wd <= w_fall ? '0 : r_wd + WD_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    // busy lingers through the done cycle so a coincident start is dropped
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (tx_start) begin
                        r_data   <= tx_data;
                        r_busy   <= 1'b1;
                        r_clk_oe <= 1'b1;
                        r_inh    <= '0;
                        r_state  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    r_inh <= r_inh + INH_ONE;
                    if (r_inh == INH_START) begin
                        r_dat_oe <= 1'b1;
                    end
                    if (r_inh == INH_LAST) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b1;
                        r_shift  <= {1'b1, ~^r_data, r_data};
                        r_wd     <= '0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_fall) begin
                        r_dat_oe <= ~r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bitcnt <= 4'd1;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_fall) begin
                        r_dat_oe <= ~r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd9) begin
                            r_state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    if (w_fall && !r_dat_sync) begin
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (r_clk_sync && r_dat_sync) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_FAIL: begin
                    r_dat_oe <= 1'b0;
                    if (w_retry) begin
                        r_clk_oe <= 1'b1;
                        r_inh    <= '0;
                        r_state  <= S_INHIBIT;
                    end else begin
                        r_clk_oe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // failure overrides any same-cycle completion
            if (w_nack || w_timeout) begin
                r_state  <= S_FAIL;
                r_clk_oe <= 1'b0;
                r_dat_oe <= 1'b0;
                r_done   <= 1'b0;
                r_error  <= ~w_retry;
            end
        end
    end

    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_ps2_tx.sv
// Scoreboard bench for ps2_tx with a bus-level PS/2 device model.
// Honours PS2_TX_RETRY_EN when the design is built with it.
module tb_ps2_tx;

    localparam int INH  = 5000;
    localparam int TMO  = 4000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       clk_line;
    logic       dat_line;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;

    int n_vec = 0;
    int n_err = 0;
    int req_cnt = 0;
    int dev_bit = -1;

    int         exp_kind_q[$];
    logic [9:0] exp_bits_q[$];
    logic [9:0] rx_q[$];
    int         plan_q[$];

    always #10 clk = ~clk;

    assign clk_line = dev_clk & ~ps2_clk_oe;
    assign dat_line = dev_dat & ~ps2_dat_oe;

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock     (clk),
        .reset     (rst),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .ps2_clk_i (clk_line),
        .ps2_dat_i (dat_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // reference frame: data LSB first, odd parity, stop = 1
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic dwell(input int n, inout bit hit);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (rst) hit = 1'b1;
        end
    endtask

    // inhibit phase tracker: length, start bit in last cycle only
    int run = 0;
    int run_dat = 0;
    always @(negedge clk) begin
        if (rst) begin
            run = 0;
            run_dat = 0;
        end else if (ps2_clk_oe) begin
            run++;
            if (ps2_dat_oe) run_dat++;
        end else if (run > 0) begin
            check("inhibit_len", run, INH);
            check("start_bit_in_inhibit", run_dat, 1);
            check("start_bit_held", ps2_dat_oe, 1);
            run = 0;
            run_dat = 0;
            req_cnt++;
        end
    end

    // mode 0 = ack, 1 = no ack, 2 = never clock
    task automatic dev_frame(input int mode);
        logic [9:0] bits;
        bit hit;
        hit = 1'b0;
        bits = '0;
        dwell(HALF, hit);
        for (int i = 0; i < 10; i++) begin
            if (hit) break;
            dev_bit = i;
            dev_clk = 1'b0;
            dwell(HALF, hit);
            bits[i] = dat_line;
            dev_clk = 1'b1;
            dwell(HALF, hit);
        end
        if (!hit) begin
            dev_dat = (mode == 0) ? 1'b0 : 1'b1;
            dwell(2, hit);
            dev_clk = 1'b0;
            dwell(HALF, hit);
            dev_clk = 1'b1;
            dwell(2, hit);
            dev_dat = 1'b1;
            if (mode == 0) rx_q.push_back(bits);
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        dev_bit = -1;
    endtask

    initial begin : device
        int seen;
        int mode;
        seen = 0;
        forever begin
            @(negedge clk);
            if (req_cnt != seen) begin
                seen = req_cnt;
                mode = (plan_q.size() > 0) ? plan_q.pop_front() : 0;
                if (mode != 2) dev_frame(mode);
            end
        end
    end

    // monitor: pops expectations whenever done/error is seen
    always @(negedge clk) begin
        int k;
        logic [9:0] e;
        if (!rst && (done || error)) begin
            check("done_error_exclusive", {31'd0, done & error}, 0);
            check("busy_at_pulse", busy, 1);
            if (exp_kind_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: done=%0b error=%0b, nothing expected", done, error);
            end else begin
                k = exp_kind_q.pop_front();
                e = exp_bits_q.pop_front();
                check("outcome_done", done, (k == 0));
                check("outcome_error", error, (k == 1));
                if (k == 0 && done) begin
                    if (rx_q.size() == 0) begin
                        fail_now("frame_missing");
                    end else begin
                        check("frame_bits", rx_q.pop_front(), e);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 4 * (INH + TMO)) begin
            @(negedge clk);
            t++;
        end
        if (busy) fail_now("wait_idle");
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_kind_q.size() != 0 || busy) && t < 4 * (INH + TMO)) begin
            @(negedge clk);
            t++;
        end
        if (exp_kind_q.size() != 0 || busy) fail_now("drain");
    endtask

    // kind: 0 = done expected, 1 = error expected, -1 = nothing expected
    task automatic send(input logic [7:0] b, input int kind);
        wait_idle();
        @(negedge clk);
        tx_data = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("start_latency_clk_oe", ps2_clk_oe, 1);
        check("busy_after_start", busy, 1);
        if (kind >= 0) begin
            exp_kind_q.push_back(kind);
            exp_bits_q.push_back(frame_of(b));
        end
    endtask

    task automatic wait_bit(input int target, input string name);
        int t;
        t = 0;
        while (dev_bit != target && t < INH + TMO) begin
            @(negedge clk);
            t++;
        end
        if (dev_bit != target) fail_now(name);
    endtask

    initial begin : stim
        int r0;
        int cnt;
        int t;
        bit hit;
        logic [7:0] rb;
        hit = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        send(8'hED, 0);
        drain();
        send(8'h01, 0);
        drain();
        send(8'hFF, 0);
        drain();

        // no acknowledge from the device
        r0 = req_cnt;
        plan_q.push_back(1);
`ifdef PS2_TX_RETRY_EN
        send(8'h3C, 0);
        drain();
        check("nack_inhibit_phases", req_cnt - r0, 2);
`else
        send(8'h3C, 1);
        drain();
        check("nack_inhibit_phases", req_cnt - r0, 1);
`endif

        // silent device: watchdog
        plan_q.push_back(2);
`ifdef PS2_TX_RETRY_EN
        plan_q.push_back(2);
`endif
        send(8'hA5, 1);
        t = 0;
        while (ps2_clk_oe && t < INH + 10) begin
            @(negedge clk);
            t++;
        end
        cnt = 0;
        while (ps2_dat_oe && cnt < TMO + 50) begin
            @(negedge clk);
            cnt++;
        end
        check("watchdog_cycles", cnt, TMO);
        check("watchdog_clk_released", ps2_clk_oe, 0);
`ifndef PS2_TX_RETRY_EN
        check("watchdog_error_pulse", error, 1);
`endif
        drain();
        check("watchdog_oe_idle", {ps2_clk_oe, ps2_dat_oe}, 0);

        // reset mid-frame while data line is pulled low for bit 4
        send(8'h0F, -1);
        wait_bit(4, "reach_bit4");
        dwell(HALF / 2, hit);
        #4 rst = 1'b1;
        #2;
        check("async_rst_clk_oe", ps2_clk_oe, 0);
        check("async_rst_dat_oe", ps2_dat_oe, 0);
        check("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_bit(-1, "device_abort");

        // start coincident with done must be dropped
        send(8'hF4, 0);
        t = 0;
        while (!done && t < 2 * (INH + TMO)) begin
            @(negedge clk);
            t++;
        end
        if (!done) fail_now("f4_done");
        tx_data = 8'h99;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("start_at_done_busy", busy, 0);
        check("start_at_done_clk_oe", ps2_clk_oe, 0);
        drain();

        // start while busy must be dropped
        send(8'h55, 0);
        wait_bit(3, "reach_bit3");
        @(negedge clk);
        tx_data = 8'hAA;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_ignores_start", busy, 1);
        drain();

        for (int i = 0; i < 2; i++) begin
            rb = 8'($urandom_range(0, 255));
            send(rb, 0);
            drain();
        end

        repeat (200) @(negedge clk);
        check("leftover_expected", exp_kind_q.size(), 0);
        check("leftover_frames", rx_q.size(), 0);
        check("final_busy", busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
